preimage_sweep_ctrl: RTL and testbench

- Sequencer that drives an external combinational 16-bit cipher block through every input value.
- Compares each output against a loadable table of target ciphertext words and reports every (input, target index) hit over a valid/ready stream.
- Replaces the simulation-only exhaustive loop with synthesizable hardware.
- Sits between a host/config interface and one instance of the cipher circuit, which is an external port pair (cand_x out, circ_y in).

---
 rtl/preimage_sweep_ctrl_pkg.sv | 16 +
 rtl/preimage_sweep_ctrl_tgt_cam.sv | 46 ++++
 rtl/preimage_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_preimage_sweep_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/preimage_sweep_ctrl_pkg.sv
// Shared types and default widths for the preimage sweep controller.
package preimage_pkg;

  localparam int W     = 16;
  localparam int N_TGT = 19;
  localparam int IDX_W = 5;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/preimage_sweep_ctrl_tgt_cam.sv
// Target ciphertext table with per-entry valid bits and a parallel
// equality compare of every valid entry against the cipher output.
module tgt_cam #(
  parameter int W     = 16,
  parameter int N_TGT = 19,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic [W-1:0]     y_i,
  output logic [N_TGT-1:0] hit_o
);
  import preimage_pkg::*;

  logic [W-1:0]     tgt_q [N_TGT];
  logic [N_TGT-1:0] valid_q;
  logic             wr_in_range_s;

  // Out-of-range indices are silently discarded.
  assign wr_in_range_s = (32'(wr_idx_i) < N_TGT);

  // Table storage: reset invalidates every entry so stale targets never match.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < N_TGT; i++) begin
        tgt_q[i] <= '0;
      end
    end else if (wr_en_i && wr_in_range_s) begin
      tgt_q[wr_idx_i]   <= wr_data_i;
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Parallel compare: only valid entries can report a hit.
  always_comb begin
    hit_o = '0;
    for (int i = 0; i < N_TGT; i++) begin
      hit_o[i] = valid_q[i] & (y_i == tgt_q[i]);
    end
  end

endmodule

// File: rtl/preimage_sweep_ctrl.sv
// Exhaustive sweep sequencer: drives every candidate into an external
// combinational cipher, matches its output against the target table and
// streams every (input, target index) hit out over valid/ready.
module preimage_sweep_ctrl #(
  parameter int W     = 16,
  parameter int N_TGT = 19,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_wr_en,
  input  logic [IDX_W-1:0] tgt_wr_idx,
  input  logic [W-1:0]     tgt_wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     cand_x,
  input  logic [W-1:0]     circ_y,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_x,
  output logic [IDX_W-1:0] m_idx,
  output logic [CNT_W-1:0] match_count
);
  import preimage_pkg::*;

  localparam logic [W-1:0]     X_MAX   = {W{1'b1}};
  localparam logic [W-1:0]     X_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N_TGT-1:0] BIT0    = {{(N_TGT-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [W-1:0]     cand_x_q;
  logic [W-1:0]     m_x_q;
  logic [IDX_W-1:0] m_idx_q;
  logic [N_TGT-1:0] hit_q;
  logic [CNT_W-1:0] match_count_q;
  logic             m_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             wr_ok_s;
  logic [N_TGT-1:0] hit_s;
  logic [IDX_W-1:0] first_idx_s;
  logic [N_TGT-1:0] rem_d;
  logic [IDX_W-1:0] next_idx_d;

  // Index of the lowest set bit; zero for an all-clear vector.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_TGT-1:0] v);
    lowest_idx = '0;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      lowest_idx = v[i] ? IDX_W'(i) : lowest_idx;
    end
  endfunction

  // The table may only change while no sweep is in flight.
  assign wr_ok_s = tgt_wr_en & ((state_q == IDLE) | (state_q == DONE));

  tgt_cam #(
    .W     (W),
    .N_TGT (N_TGT),
    .IDX_W (IDX_W)
  ) u_tgt_cam (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_ok_s),
    .wr_idx_i  (tgt_wr_idx),
    .wr_data_i (tgt_wr_data),
    .y_i       (circ_y),
    .hit_o     (hit_s)
  );

  // Priority encode the fresh hit vector and the remainder after popping a beat.
  always_comb begin
    first_idx_s = lowest_idx(hit_s);
    rem_d       = hit_q & ~(BIT0 << m_idx_q);
    next_idx_d  = lowest_idx(rem_d);
  end

  // Main FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cand_x_q      <= '0;
      m_x_q         <= '0;
      m_idx_q       <= '0;
      hit_q         <= '0;
      match_count_q <= '0;
      m_valid_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q       <= SWEEP;
            cand_x_q      <= '0;
            match_count_q <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        SWEEP: begin
          if (hit_s != '0) begin
            // Freeze the candidate and hand the hits to the emitter.
            state_q   <= EMIT;
            hit_q     <= hit_s;
            m_x_q     <= cand_x_q;
            m_idx_q   <= first_idx_s;
            m_valid_q <= 1'b1;
          end else if (cand_x_q == X_MAX) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cand_x_q <= cand_x_q + X_ONE;
          end
        end
        EMIT: begin
          if (m_valid_q && m_ready) begin
            hit_q <= rem_d;
            if (match_count_q != {CNT_W{1'b1}}) begin
              match_count_q <= match_count_q + CNT_ONE;
            end
            if (rem_d != '0) begin
              m_idx_q <= next_idx_d;
            end else begin
              m_valid_q <= 1'b0;
              if (m_x_q == X_MAX) begin
                // Last candidate already emitted: finish without rollover.
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q  <= SWEEP;
                cand_x_q <= m_x_q + X_ONE;
              end
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cand_x      = cand_x_q;
  assign m_valid     = m_valid_q;
  assign m_x         = m_x_q;
  assign m_idx       = m_idx_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_preimage_sweep_ctrl.sv
// Scoreboard bench for preimage_sweep_ctrl with cipher model y = x ^ 16'h1234.
module tb_preimage_sweep_ctrl;
  import preimage_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             tgt_wr_en;
  logic [IDX_W-1:0] tgt_wr_idx;
  logic [W-1:0]     tgt_wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [W-1:0]     cand_x;
  logic [W-1:0]     circ_y;
  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_x;
  logic [IDX_W-1:0] m_idx;
  logic [CNT_W-1:0] match_count;

  typedef struct packed {
    logic [W-1:0]     x;
    logic [IDX_W-1:0] idx;
  } beat_t;

  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  assign circ_y = cand_x ^ 16'h1234;

  preimage_sweep_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tgt_wr_en   (tgt_wr_en),
    .tgt_wr_idx  (tgt_wr_idx),
    .tgt_wr_data (tgt_wr_data),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .cand_x      (cand_x),
    .circ_y      (circ_y),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_x         (m_x),
    .m_idx       (m_idx),
    .match_count (match_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [W-1:0] x, input logic [IDX_W-1:0] idx);
    beat_t b;
    b.x   = x;
    b.idx = idx;
    sb_q.push_back(b);
  endtask

  task automatic wr_tgt(input logic [IDX_W-1:0] idx, input logic [W-1:0] data);
    @(negedge clk);
    tgt_wr_en   = 1'b1;
    tgt_wr_idx  = idx;
    tgt_wr_data = data;
    @(negedge clk);
    tgt_wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got x=%h idx=%0d, expected no beat", m_x, m_idx);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        chk("beat_x", 32'(m_x), 32'(e.x));
        chk("beat_idx", 32'(m_idx), 32'(e.idx));
      end
    end
  end

  initial begin
    int cnt;
    bit seen;

    rst         = 1'b1;
    tgt_wr_en   = 1'b0;
    tgt_wr_idx  = '0;
    tgt_wr_data = '0;
    start       = 1'b0;
    m_ready     = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cand_x", 32'(cand_x), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_x", 32'(m_x), 32'd0);
    chk("rst_m_idx", 32'(m_idx), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    rst = 1'b0;

    // Full sweep: hits ascend in x, last-input hit, dropped write while busy
    wr_tgt(5'd0, 16'h4507);
    wr_tgt(5'd3, 16'h045D);
    wr_tgt(5'd18, 16'hEDCB);
    push_beat(16'h1669, 5'd3);
    push_beat(16'h5733, 5'd0);
    push_beat(16'hFFFF, 5'd18);
    pulse_start();
    cnt = 0;
    for (int n = 0; n < 70000; n++) begin
      if (!busy) break;
      cnt++;
      if (cnt == 2) begin
        tgt_wr_en   = 1'b1;
        tgt_wr_idx  = 5'd5;
        tgt_wr_data = 16'h0000;
      end
      if (cnt == 3) tgt_wr_en = 1'b0;
      @(negedge clk);
    end
    chk("sweep_busy_cycles", 32'(cnt), 32'd65539);
    chk("sweep_done", 32'(done), 32'd1);
    chk("sweep_end_x", 32'(cand_x), 32'h0000FFFF);
    chk("sweep_count", 32'(match_count), 32'd3);
    chk("sweep_m_valid", 32'(m_valid), 32'd0);
    chk("sweep_sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    chk("done_hold", 32'(done), 32'd1);
    chk("no_rollover", 32'(cand_x), 32'h0000FFFF);

    // Reset mid-sweep at x=0x0100
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (cand_x == 16'h0100) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wait_x100", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_cand_x", 32'(cand_x), 32'd0);
    chk("abort_m_x", 32'(m_x), 32'd0);
    chk("abort_count", 32'(match_count), 32'd0);
    rst = 1'b0;

    // Restart without reload: no target may match
    pulse_start();
    repeat (16'h1800) @(negedge clk);
    chk("noreload_x", 32'(cand_x), 32'h00001800);
    chk("noreload_busy", 32'(busy), 32'd1);
    chk("noreload_count", 32'(match_count), 32'd0);
    pulse_rst();

    // Duplicate targets with back-pressure
    wr_tgt(5'd2, 16'h0000);
    wr_tgt(5'd7, 16'h0000);
    push_beat(16'h1234, 5'd2);
    push_beat(16'h1234, 5'd7);
    m_ready = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 16'h1400; n++) begin
      if (m_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wait_dup_valid", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_m_x", 32'(m_x), 32'h00001234);
      chk("stall_m_idx", 32'(m_idx), 32'd2);
      chk("stall_cand_x", 32'(cand_x), 32'h00001234);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("dup_resume_x", 32'(cand_x), 32'h00001235);
    chk("dup_count", 32'(match_count), 32'd2);
    chk("dup_m_valid", 32'(m_valid), 32'd0);
    chk("dup_sb_empty", 32'(sb_q.size()), 32'd0);
    pulse_rst();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
